// File: rtl/rr_ex_pr_pkg.sv
// rr_ex_pkg: field widths and the packed RR->EX bundle shared by the
// pipeline register, its interface and anything that inspects the stage.
package rr_ex_pkg;

    localparam int PC_W   = 32;
    localparam int CTRL_W = 7;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;

    // Everything that travels from RR into EX for one instruction.
    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [CTRL_W-1:0] ctrl;
        logic [IDX_W-1:0]  dst_idx;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [LEN_W-1:0]  len;
    } rr_ex_bundle_t;

    // A bubble is fully zero, data fields included.
    localparam rr_ex_bundle_t RR_EX_BUBBLE = '0;

endpackage

// File: rtl/rr_ex_pr_if.sv
// rr_ex_pr_if: RR-side inputs and EX-side registered outputs of the
// RR/EX pipeline register. The producer/observer uses master, the
// register itself uses slave.
interface rr_ex_pr_if #(
    parameter int PC_W   = rr_ex_pkg::PC_W,
    parameter int CTRL_W = rr_ex_pkg::CTRL_W,
    parameter int IDX_W  = rr_ex_pkg::IDX_W,
    parameter int DATA_W = rr_ex_pkg::DATA_W,
    parameter int LEN_W  = rr_ex_pkg::LEN_W
);
    logic [LEN_W-1:0]  instr_length_in;
    logic [PC_W-1:0]   pc_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic [IDX_W-1:0]  dst_idx_in;
    logic [DATA_W-1:0] src1_in;
    logic [DATA_W-1:0] src2_in;
    logic              valid_in;

    logic [LEN_W-1:0]  instr_length_out;
    logic [PC_W-1:0]   pc_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [IDX_W-1:0]  dst_idx_out;
    logic [DATA_W-1:0] src1_out;
    logic [DATA_W-1:0] src2_out;
    logic              valid_out;

    modport master (
        output instr_length_in, pc_in, ctrl_in, dst_idx_in, src1_in, src2_in, valid_in,
        input  instr_length_out, pc_out, ctrl_out, dst_idx_out, src1_out, src2_out, valid_out
    );

    modport slave (
        input  instr_length_in, pc_in, ctrl_in, dst_idx_in, src1_in, src2_in, valid_in,
        output instr_length_out, pc_out, ctrl_out, dst_idx_out, src1_out, src2_out, valid_out
    );
endinterface

// File: rtl/rr_ex_pr_field_reg.sv
// pr_field_reg: W-bit register with synchronous clear (highest priority)
// and load enable. Clear is used for both reset and flush.
module pr_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear beats enable, so a flush during a stall still squashes.
    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/rr_ex_pr.sv
// rr_ex_pr: RR -> EX pipeline register with stall (hold) and flush
// (load an all-zero bubble). Priority: rst > flush > stall > load.
// Optional build macro RR_EX_PR_PERF_EN adds saturating stall/flush
// event counters on stall_cnt_out / flush_cnt_out.
module rr_ex_pr
    import rr_ex_pkg::*;
#(
    parameter int PC_W   = rr_ex_pkg::PC_W,
    parameter int CTRL_W = rr_ex_pkg::CTRL_W,
    parameter int IDX_W  = rr_ex_pkg::IDX_W,
    parameter int DATA_W = rr_ex_pkg::DATA_W,
    parameter int LEN_W  = rr_ex_pkg::LEN_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    rr_ex_pr_if.slave   bus
`ifdef RR_EX_PR_PERF_EN
    ,
    output logic [31:0] stall_cnt_out,
    output logic [31:0] flush_cnt_out
`endif
);

    logic clr;
    logic en;

    // Reset and flush both produce a bubble; stall only gates the load.
    assign clr = rst | flush;
    assign en  = ~stall;

    pr_field_reg #(.W(PC_W)) u_pc (
        .clk(clk), .clr(clr), .en(en), .d(bus.pc_in), .q(bus.pc_out)
    );

    pr_field_reg #(.W(CTRL_W)) u_ctrl (
        .clk(clk), .clr(clr), .en(en), .d(bus.ctrl_in), .q(bus.ctrl_out)
    );

    pr_field_reg #(.W(IDX_W)) u_dst (
        .clk(clk), .clr(clr), .en(en), .d(bus.dst_idx_in), .q(bus.dst_idx_out)
    );

    pr_field_reg #(.W(DATA_W)) u_src1 (
        .clk(clk), .clr(clr), .en(en), .d(bus.src1_in), .q(bus.src1_out)
    );

    pr_field_reg #(.W(DATA_W)) u_src2 (
        .clk(clk), .clr(clr), .en(en), .d(bus.src2_in), .q(bus.src2_out)
    );

    pr_field_reg #(.W(LEN_W)) u_len (
        .clk(clk), .clr(clr), .en(en), .d(bus.instr_length_in), .q(bus.instr_length_out)
    );

    pr_field_reg #(.W(1)) u_valid (
        .clk(clk), .clr(clr), .en(en), .d(bus.valid_in), .q(bus.valid_out)
    );

`ifdef RR_EX_PR_PERF_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    // Count effective stalls (not overridden by flush) and flushes; saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall && !flush && stall_cnt_reg != CNT_MAX)
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            if (flush && flush_cnt_reg != CNT_MAX)
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_reg;
    assign flush_cnt_out = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_rr_ex_pr.sv
// tb_rr_ex_pr: directed vectors for the RR/EX pipeline register. Each
// vector pushes its hand-computed post-edge state into a queue; a
// monitor pops one entry after every clock edge and compares.
module tb_rr_ex_pr;
    import rr_ex_pkg::*;

    typedef struct {
        int            id;
        rr_ex_bundle_t exp;
        int unsigned   scnt;
        int unsigned   fcnt;
    } exp_t;

    logic clk;
    logic rst;
    logic stall;
    logic flush;

    rr_ex_pr_if bus ();

`ifdef RR_EX_PR_PERF_EN
    logic [31:0] stall_cnt_out;
    logic [31:0] flush_cnt_out;
`endif

    rr_ex_pr dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus.slave)
`ifdef RR_EX_PR_PERF_EN
        ,
        .stall_cnt_out (stall_cnt_out),
        .flush_cnt_out (flush_cnt_out)
`endif
    );

    exp_t exp_q[$];
    int   applied;
    int   miscompares;
    int   vec_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one registered result per edge, checked 1 ns after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t          e;
            rr_ex_bundle_t act;
            bit            bad;
            e   = exp_q.pop_front();
            act = '{valid:   bus.valid_out,
                    pc:      bus.pc_out,
                    ctrl:    bus.ctrl_out,
                    dst_idx: bus.dst_idx_out,
                    src1:    bus.src1_out,
                    src2:    bus.src2_out,
                    len:     bus.instr_length_out};
            bad = (act !== e.exp);
`ifdef RR_EX_PR_PERF_EN
            if (stall_cnt_out !== e.scnt || flush_cnt_out !== e.fcnt) begin
                bad = 1'b1;
                $display("FAIL vec%0d counters: stall_cnt=%0d flush_cnt=%0d, required %0d/%0d",
                         e.id, stall_cnt_out, flush_cnt_out, e.scnt, e.fcnt);
            end
`endif
            applied++;
            if (bad) begin
                miscompares++;
                $display("FAIL vec%0d bundle: got v=%0b pc=%h ctrl=%h dst=%0d s1=%h s2=%h len=%0d, required v=%0b pc=%h ctrl=%h dst=%0d s1=%h s2=%h len=%0d",
                         e.id, act.valid, act.pc, act.ctrl, act.dst_idx, act.src1, act.src2, act.len,
                         e.exp.valid, e.exp.pc, e.exp.ctrl, e.exp.dst_idx, e.exp.src1, e.exp.src2, e.exp.len);
            end else begin
                $display("vec%0d ok: v=%0b pc=%h ctrl=%h dst=%0d s1=%h s2=%h len=%0d",
                         e.id, act.valid, act.pc, act.ctrl, act.dst_idx, act.src1, act.src2, act.len);
            end
        end
    end

    function automatic rr_ex_bundle_t mk(input logic v, input logic [31:0] pc,
                                         input logic [6:0] ctrl, input logic [2:0] dst,
                                         input logic [31:0] s1, input logic [31:0] s2,
                                         input logic [2:0] len);
        rr_ex_bundle_t b;
        b = '{valid: v, pc: pc, ctrl: ctrl, dst_idx: dst, src1: s1, src2: s2, len: len};
        return b;
    endfunction

    // Drive one vector on the falling edge and queue its expected result.
    task automatic apply(input logic r, input logic s, input logic f,
                         input rr_ex_bundle_t din, input rr_ex_bundle_t exp,
                         input int unsigned scnt, input int unsigned fcnt);
        exp_t e;
        @(negedge clk);
        rst                 = r;
        stall               = s;
        flush               = f;
        bus.valid_in        = din.valid;
        bus.pc_in           = din.pc;
        bus.ctrl_in         = din.ctrl;
        bus.dst_idx_in      = din.dst_idx;
        bus.src1_in         = din.src1;
        bus.src2_in         = din.src2;
        bus.instr_length_in = din.len;
        e.id   = vec_id;
        e.exp  = exp;
        e.scnt = scnt;
        e.fcnt = fcnt;
        exp_q.push_back(e);
        vec_id++;
    endtask

    rr_ex_bundle_t a_in, b_in, c_in, d_in, junk;

    initial begin
        applied     = 0;
        miscompares = 0;
        vec_id      = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        bus.valid_in = 1'b0; bus.pc_in = '0; bus.ctrl_in = '0; bus.dst_idx_in = '0;
        bus.src1_in = '0; bus.src2_in = '0; bus.instr_length_in = '0;

        a_in = mk(1'b1, 32'hAAAA_5555, 7'b1110000, 3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 3'd4);
        b_in = mk(1'b1, 32'h0000_1000, 7'h05,      3'd3, 32'hFFFF_FFFF, 32'h0000_0001, 3'd1);
        c_in = mk(1'b1, 32'h8000_0000, 7'h7F,      3'd5, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'd7);
        d_in = mk(1'b0, 32'h0000_1234, 7'h2A,      3'd1, 32'hCAFE_0000, 32'h0000_BABE, 3'd2);
        junk = mk(1'b0, 32'hDEAD_BEEF, 7'h11,      3'd2, 32'h0000_0000, 32'h5555_AAAA, 3'd6);

        // reset with junk on the inputs
        apply(1, 0, 0, a_in, RR_EX_BUBBLE, 0, 0);
        // first edge after reset is stalled: outputs stay zero
        apply(0, 1, 0, a_in, RR_EX_BUBBLE, 1, 0);
        // normal load
        apply(0, 0, 0, a_in, a_in, 1, 0);
        // stall: hold A despite new inputs
        apply(0, 1, 0, junk, a_in, 2, 0);
        // flush with a valid instruction at the input
        apply(0, 0, 1, mk(1'b1, 32'hFFFF_FFFF, 7'h7F, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7),
              RR_EX_BUBBLE, 2, 1);
        // load B
        apply(0, 0, 0, b_in, b_in, 2, 1);
        // flush overrides stall; stall not counted
        apply(0, 1, 1, c_in, RR_EX_BUBBLE, 2, 2);
        // load C (all-ones ctrl, max len)
        apply(0, 0, 0, c_in, c_in, 2, 2);
        // two stalls in a row hold C
        apply(0, 1, 0, b_in, c_in, 3, 2);
        apply(0, 1, 0, junk, c_in, 4, 2);
        // invalid instruction: data is still captured, valid_out=0
        apply(0, 0, 0, d_in, d_in, 4, 2);
        // back-to-back loads
        apply(0, 0, 0, a_in, a_in, 4, 2);
        apply(0, 0, 0, b_in, b_in, 4, 2);
        // reset during stall clears everything, counters included
        apply(1, 1, 0, c_in, RR_EX_BUBBLE, 0, 0);
        // reset during flush
        apply(0, 0, 0, c_in, c_in, 0, 0);
        apply(1, 0, 1, a_in, RR_EX_BUBBLE, 0, 0);
        // flush right after reset, then a load
        apply(0, 0, 1, a_in, RR_EX_BUBBLE, 0, 1);
        apply(0, 0, 0, d_in, d_in, 0, 1);

        // Let the monitor drain; bounded so a stuck queue still ends.
        @(negedge clk);
        rst = 1'b0; stall = 1'b1; flush = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
